// File: rtl/ex_muldiv_if.sv
// Execute-stage request/response bundle for ex_muldiv_unit.
// master = execute stage, slave = the multiply/divide unit.
interface ex_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic [XLEN-1:0] result;
  logic            done;
  logic            busy;
  logic            stall;

  modport master (
    output start, op, a, b, flush,
    input  result, done, busy, stall
  );

  modport slave (
    input  start, op, a, b, flush,
    output result, done, busy, stall
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit for the execute stage.
// Define EX_MULDIV_DIV_EN to build the divider; otherwise divide ops return 0 in one cycle.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);
  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN + 1);
`ifdef EX_MULDIV_DIV_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] opnd_q;
  logic [PW-1:0]   prod_q;
  logic [PW-1:0]   prod_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;
  logic            done_q;
  logic            busy_q;

  logic            sgn_a_c, sgn_b_c, neg_a_c, neg_b_c, neg_res_c;
  logic [XLEN-1:0] mag_a_c, mag_b_c;
  logic            fast_c;
  logic [XLEN-1:0] fast_res_c;
  logic [XLEN:0]   mul_sum_c;
  logic [PW-1:0]   prod_neg_c;
  logic [XLEN-1:0] lo_c, hi_c, fin_c;
`ifdef EX_MULDIV_DIV_EN
  logic [XLEN:0]   div_shift_c, div_diff_c;
`endif

  // Operand sign handling at accept; magnitudes feed the unsigned datapath.
  always_comb begin
    sgn_a_c   = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                (bus.op == 3'b100) || (bus.op == 3'b110);
    sgn_b_c   = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    neg_a_c   = sgn_a_c && bus.a[XLEN-1];
    neg_b_c   = sgn_b_c && bus.b[XLEN-1];
    mag_a_c   = neg_a_c ? -bus.a : bus.a;
    mag_b_c   = neg_b_c ? -bus.b : bus.b;
    neg_res_c = (bus.op[2] && bus.op[1]) ? neg_a_c : (neg_a_c ^ neg_b_c);
  end

  // One-cycle results that bypass the iterative datapath.
  always_comb begin
    fast_c     = 1'b0;
    fast_res_c = '0;
`ifdef EX_MULDIV_DIV_EN
    if (bus.op[2]) begin
      if (bus.b == '0) begin
        fast_c     = 1'b1;
        fast_res_c = bus.op[1] ? bus.a : '1;
      end else if (!bus.op[0] && (bus.a == SMIN) && (bus.b == '1)) begin
        fast_c     = 1'b1;
        fast_res_c = bus.op[1] ? '0 : bus.a;
      end
    end
`else
    fast_c     = bus.op[2];
`endif
  end

  // Radix-2 step: prod_q is {acc, multiplier} for MUL and {rem, quotient} for DIV.
  always_comb begin
    mul_sum_c = {1'b0, prod_q[PW-1:XLEN]} + {1'b0, opnd_q};
    prod_d    = prod_q[0] ? {mul_sum_c, prod_q[XLEN-1:1]} : {1'b0, prod_q[PW-1:1]};
`ifdef EX_MULDIV_DIV_EN
    div_shift_c = prod_q[PW-1:XLEN-1];
    div_diff_c  = div_shift_c - {1'b0, opnd_q};
    if (op_q[2]) begin
      prod_d = div_diff_c[XLEN] ? {div_shift_c[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                : {div_diff_c[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    end
`endif
  end

  // Sign fix-up and result selection from the final step.
  always_comb begin
    prod_neg_c = -prod_d;
    lo_c       = neg_q ? -prod_d[XLEN-1:0]  : prod_d[XLEN-1:0];
    hi_c       = neg_q ? -prod_d[PW-1:XLEN] : prod_d[PW-1:XLEN];
    case (op_q)
      3'b000:                 fin_c = prod_d[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_c = neg_q ? prod_neg_c[PW-1:XLEN] : prod_d[PW-1:XLEN];
      3'b100, 3'b101:         fin_c = lo_c;
      default:                fin_c = hi_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q   <= bus.op;
            neg_q  <= neg_res_c;
            opnd_q <= mag_b_c;
            prod_q <= {{XLEN{1'b0}}, mag_a_c};
            cnt_q  <= CW'(XLEN);
            busy_q <= 1'b1;
            if (fast_c) begin
              state_q  <= DONE;
              result_q <= fast_res_c;
              done_q   <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q  <= DONE;
              result_q <= fin_c;
              done_q   <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stall is the lone combinational output so the front end freezes in the accept cycle.
  assign bus.stall  = !rst && (((state_q == IDLE) && bus.start && !bus.flush) ||
                               (state_q == RUN));
  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed + scoreboard bench for ex_muldiv_unit (XLEN=32), aware of EX_MULDIV_DIV_EN.
module tb_ex_muldiv_unit;
  localparam int unsigned XLEN = 32;
  localparam int LAT = XLEN + 1;
`ifdef EX_MULDIV_DIV_EN
  localparam int DLAT = LAT;
`else
  localparam int DLAT = 1;
`endif

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_exp = '0;
  exp_t sbq[$];

  ex_muldiv_if #(.XLEN(XLEN)) bus ();
  ex_muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation, value and cycle.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      checks++;
      assert (sbq.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_done: observed=done at cycle %0d expected=no done", cyc);
      end
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("result", bus.result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (op)
      3'd0: begin p = ua * ub;          r = p[31:0];  end
      3'd1: begin p = 64'(sa * sb);     r = p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); r = p[63:32]; end
      3'd3: begin p = ua * ub;          r = p[63:32]; end
      default: begin
`ifdef EX_MULDIV_DIV_EN
        if (b == 32'd0) r = op[1] ? a : 32'hFFFF_FFFF;
        else begin
          case (op)
            3'd4:    r = 32'(sa / sb);
            3'd5:    r = 32'(ua / ub);
            3'd6:    r = 32'(sa % sb);
            default: r = 32'(ua % ub);
          endcase
        end
`else
        r = '0;
`endif
      end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef EX_MULDIV_DIV_EN
    if (op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return LAT;
`else
    return op[2] ? 1 : LAT;
`endif
  endfunction

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    e.res     = exp;
    e.cyc     = cyc + lat;
    sbq.push_back(e);
    last_exp  = exp;
  endtask

  // Walks cycles 0..lat counting stall, then checks the unit is idle in cycle lat+1.
  task automatic complete(input string tag, input int lat);
    int st = 0;
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      if (bus.stall === 1'b1) st++;
      @(posedge clk); #1;
      if (i == 0) begin
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
    end
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_stall_cycles"}, 32'(st), 32'(lat));
    check({tag, "_done_seen"}, 32'(sbq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    launch(op, a, b, exp, lat);
    complete(tag, lat);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 32'd7;
    bus.b     = 32'd6;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;

    run("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42, LAT);
    run("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT);
    run("mul_m1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT);
    run("mulhu_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
    run("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
    run("mul_by0", 3'b000, 32'h1234_5678, 32'd0, 32'd0, LAT);

`ifdef EX_MULDIV_DIV_EN
    run("div_m20_3", 3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, LAT);
    run("rem_m20_3", 3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, LAT);
    run("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, LAT);
    run("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, LAT);
    run("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
`else
    run("div_off", 3'b100, 32'd100, 32'd7, 32'd0, 1);
    run("remu_off", 3'b111, 32'd100, 32'd7, 32'd0, 1);
    run("divu_off_by0", 3'b101, 32'd5, 32'd0, 32'd0, 1);
`endif

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'(i);
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      run("rand", op, a, b, ref_res(op, a, b), ref_lat(op, a, b));
    end

    run("mul_pre_flush", 3'b000, 32'd7, 32'd6, 32'd42, LAT);

    // Flush in cycle 10 of a long op; new request in cycle 11.
    bus.start = 1'b1;
`ifdef EX_MULDIV_DIV_EN
    bus.op    = 3'b100;
`else
    bus.op    = 3'b011;
`endif
    bus.a     = 32'd1000;
    bus.b     = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    #1;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_stall", 32'(bus.stall), 32'd0);
    check("flush_result_held", bus.result, last_exp);
    launch(3'b000, 32'd9, 32'd9, 32'd81, LAT);
    complete("post_flush", LAT);

    // Reset asserted in cycle 5 of a MUL.
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.a     = 32'd123;
    bus.b     = 32'd456;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_done", 32'(bus.done), 32'd0);
    check("post_rst_result", bus.result, 32'd0);
    @(posedge clk); #1;

    // start held through a whole op: one done per accept, re-accept after DONE.
    launch(3'b000, 32'd3, 32'd5, 32'd15, LAT);
    begin
      exp_t e2;
      e2.res = 32'd15;
      e2.cyc = cyc + 2 * LAT + 1;
      sbq.push_back(e2);
    end
    repeat (LAT + 1) begin @(posedge clk); #1; end
    @(negedge clk);
    check("held_idle_busy", 32'(bus.busy), 32'd0);
    check("held_idle_stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (LAT) begin @(posedge clk); #1; end
    @(negedge clk);
    check("held_all_done", 32'(sbq.size()), 32'd0);
    check("held_busy_after", 32'(bus.busy), 32'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit for the execute stage, implementing the RV32M/RV64M operation set over a parametrised datapath width. It sits beside the ALU, takes already-forwarded operands and funct3 from the execute stage, and stalls the front of the pipeline while it iterates. It releases the stall in the cycle its result is valid so writeback captures it.

## Interface
- XLEN, 32, operand/result width; any even value ≥ 8.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand, after forwarding.
- b  input  XLEN  rs2 operand, after forwarding.
- flush  input  1  kill the in-flight operation (branch taken or trap).
- result  output  XLEN  registered result; holds until the next accepted start.
- done  output  1  one-cycle pulse; result valid.
- busy  output  1  state is not IDLE.
- stall  output  1  freeze PC and the execute stage.

## Operation
- States: IDLE, RUN, DONE.
- Accept:
  - Condition: start & ~flush in IDLE.
  - Latch op, operand magnitudes and sign flags.
  - Load the iteration counter with XLEN.
  - Go to RUN.
  - Fast-path ops skip RUN and go straight to DONE.
- RUN: one radix-2 step per cycle.
  - MUL*: shift-add on magnitudes into a 2·XLEN product register.
  - DIV*/REM*: restoring shift-subtract on magnitudes.
  - When the counter reaches 0, go to DONE.
- DONE:
  - done=1 and result updated.
  - Next state is IDLE.
  - A start in the DONE cycle is ignored; the new request is accepted in the following IDLE cycle.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Negate the product if the operand signs differ.
  - The quotient takes sign(a)^sign(b).
  - The remainder takes sign(a).
- Result selection:
  - MUL: product[XLEN-1:0].
  - MULH/MULHSU/MULHU: product[2·XLEN-1:XLEN].
- Fast paths (one cycle, straight to DONE):
  - b==0: DIV/DIVU return all-ones; REM/REMU return a.
  - DIV with a=−2^(XLEN−1) and b=−1: quotient a, REM 0.
- Flush:
  - In RUN or DONE, next state is IDLE with done=0.
  - result is not updated.
  - flush in IDLE with start drops the start.
- start while busy is ignored; no queueing.
- Reset: state IDLE, result 0, done 0, busy 0, counter 0. rst dominates flush and start.

## Timing
- stall = (IDLE & start & ~flush) | RUN. This is the only combinational path from inputs to outputs. It is 0 in DONE and during rst.
- Normal op, start high in cycle 0:
  - RUN in cycles 1..XLEN.
  - DONE in cycle XLEN+1.
  - Latency XLEN+1; stall high in cycles 0..XLEN.
- Fast-path op, start in cycle 0: DONE in cycle 1, stall high only in cycle 0.
- Back-to-back ops: minimum issue interval XLEN+2 cycles.
- Operands a/b need only be valid in the accept cycle; they are ignored afterward.

## Configuration
- EX_MULDIV_DIV_EN defined:
  - Divider datapath and the divide fast paths are built.
  - All eight ops behave as above.
- EX_MULDIV_DIV_EN undefined:
  - No divider logic is built.
  - Ops 100–111 take the one-cycle fast path with result 0.
  - MUL ops are unchanged.

## Test plan
All scenarios use XLEN=32; cycle 0 is the start cycle.
- MUL, a=7, b=6 -> stall high cycles 0–32; done and result=42 in cycle 33; busy low cycle 34.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0; MUL same operands -> 1; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF.
- DIV a=−20, b=3 -> 0xFFFFFFFA (−6) at cycle 33; REM same operands -> 0xFFFFFFFE (−2); DIVU 100/7 -> 14; REMU -> 2.
- Divide by zero and overflow:
  - DIVU 5/0 -> 0xFFFFFFFF, done in cycle 1.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - With the macro undefined, DIV 100/7 -> 0 in cycle 1.
- Flush in cycle 10 of a DIV -> no done pulse; busy and stall low from cycle 11; result keeps its prior value; a start in cycle 11 is accepted and completes in cycle 44.
- Reset and ignored starts:
  - rst asserted in cycle 5 of a MUL -> cycle 6 shows IDLE, result=0, done=0.
  - start held high through a whole op -> exactly one done per accept, with re-accept in the IDLE cycle after DONE.
